// File: rtl/string_streamer_pkg.sv
// Shared definitions for the string streamer: FSM state encoding, the blank
// glyph default and the character-code table used to build the string ROM.
package string_streamer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    WAIT,
    FIN
  } state_e;

  localparam int SPACE_CODE_DEF = 28;

  // Letters A..Z map to codes 0..25; the few punctuation glyphs follow them.
  localparam logic [4:0] CH_A     = 5'd0;
  localparam logic [4:0] CH_Z     = 5'd25;
  localparam logic [4:0] CH_DOT   = 5'd26;
  localparam logic [4:0] CH_BANG  = 5'd27;
  localparam logic [4:0] CH_SPACE = 5'd28;
  localparam logic [4:0] CH_DASH  = 5'd29;
  localparam logic [4:0] CH_QMARK = 5'd30;
  localparam logic [4:0] CH_COLON = 5'd31;

  function automatic logic [4:0] ascii_to_code(input logic [7:0] c);
    logic [4:0] code;
    code = CH_SPACE;
    if (c >= 8'h41 && c <= 8'h5A) begin
      code = 5'(c - 8'h41);
    end else begin
      case (c)
        8'h2E:   code = CH_DOT;
        8'h21:   code = CH_BANG;
        8'h2D:   code = CH_DASH;
        8'h3F:   code = CH_QMARK;
        8'h3A:   code = CH_COLON;
        default: code = CH_SPACE;
      endcase
    end
    return code;
  endfunction

endpackage

// File: rtl/string_rom_param.sv
// Constant string table with a registered read port, written as a case-based
// lookup so synthesis maps it onto block ROM.
module string_rom_param
  import string_streamer_pkg::*;
#(
  parameter int CHAR_WIDTH = 5,
  parameter int MAX_CHAR   = 16,
  parameter int STRING_NUM = 8
) (
  input  logic                                clk_i,
  input  logic [$clog2(STRING_NUM+1)-1:0]     addr_i,
  output logic [CHAR_WIDTH*MAX_CHAR-1:0]      data_o
);

  localparam int ADDR_W = $clog2(STRING_NUM + 1);
  localparam int WORD_W = CHAR_WIDTH * MAX_CHAR;

  logic [WORD_W-1:0] data_q;

  // Text is 16 ASCII bytes; slots past the text (or NUL bytes) become blanks.
  function automatic logic [WORD_W-1:0] pack_text(input logic [127:0] text);
    logic [WORD_W-1:0] w;
    logic [127:0]      rest;
    logic [7:0]        ch;
    w    = '0;
    rest = text;
    for (int i = 0; i < MAX_CHAR; i++) begin
      ch   = rest[127:120];
      rest = rest << 8;
      w    = (w << CHAR_WIDTH) | WORD_W'(CHAR_WIDTH'(ascii_to_code(ch)));
    end
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    logic [WORD_W-1:0] w;
    case (32'(a))
      0:       w = pack_text("HELLO WORLD TEST");
      1:       w = pack_text("PRESS START     ");
      2:       w = pack_text("                ");
      3:       w = pack_text("LEVEL UP!       ");
      4:       w = pack_text("PAUSED          ");
      5:       w = pack_text("YOU WIN!        ");
      6:       w = pack_text("READY?          ");
      7:       w = pack_text("SCORE: HIGH     ");
      default: w = pack_text("                ");
    endcase
    return w;
  endfunction

  always_ff @(posedge clk_i) begin
    data_q <= rom_word(addr_i);
  end

  assign data_o = data_q;

endmodule

// File: rtl/string_streamer.sv
// Streams one ROM string as a valid/ready character sequence, with optional
// trailing-blank trimming and tick-paced typewriter reveal.
module string_streamer
  import string_streamer_pkg::*;
#(
  parameter int CHAR_WIDTH = 5,
  parameter int MAX_CHAR   = 16,
  parameter int STRING_NUM = 8,
  parameter int SPACE_CODE = SPACE_CODE_DEF,
  parameter int REVEAL_DIV = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [$clog2(STRING_NUM+1)-1:0]   str_sel,
  input  logic                              trim_en,
  input  logic                              reveal_en,
  input  logic                              tick,
  input  logic                              char_ready,
  output logic                              char_valid,
  output logic [CHAR_WIDTH-1:0]             char_code,
  output logic [$clog2(MAX_CHAR)-1:0]       char_idx,
  output logic                              char_last,
  output logic                              busy,
  output logic                              done,
  output logic                              err
);

  localparam int SEL_W  = $clog2(STRING_NUM + 1);
  localparam int IDX_W  = $clog2(MAX_CHAR);
  localparam int LEN_W  = $clog2(MAX_CHAR + 1);
  localparam int CNT_W  = $clog2(REVEAL_DIV + 1);
  localparam int WORD_W = CHAR_WIDTH * MAX_CHAR;

  localparam logic [SEL_W-1:0]      SEL_LIMIT = SEL_W'(STRING_NUM);
  localparam logic [CHAR_WIDTH-1:0] SPACE_C   = CHAR_WIDTH'(SPACE_CODE);
  localparam logic [CNT_W-1:0]      DIV_C     = CNT_W'(REVEAL_DIV);

  state_e                 state_q;
  logic [SEL_W-1:0]       sel_q;
  logic                   trim_q;
  logic                   reveal_q;
  logic                   phase_q;
  logic [IDX_W-1:0]       idx_q;
  logic [LEN_W-1:0]       len_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   valid_q;
  logic [CHAR_WIDTH-1:0]  code_q;
  logic                   last_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   err_q;

  logic [WORD_W-1:0]      rom_data;
  logic [LEN_W-1:0]       len_d;
  logic [IDX_W-1:0]       idx_d;
  logic [CNT_W-1:0]       cnt_d;
  logic                   accept;
  logic                   sel_ok;

  // The address only changes in IDLE, so the ROM output holds the word for
  // the whole stream and doubles as the registered string buffer.
  string_rom_param #(
    .CHAR_WIDTH (CHAR_WIDTH),
    .MAX_CHAR   (MAX_CHAR),
    .STRING_NUM (STRING_NUM)
  ) u_rom (
    .clk_i  (clk),
    .addr_i (sel_q),
    .data_o (rom_data)
  );

  function automatic logic [CHAR_WIDTH-1:0] code_at(input logic [WORD_W-1:0] w,
                                                    input logic [IDX_W-1:0]  i);
    logic [WORD_W-1:0] sh;
    sh = w << (int'(i) * CHAR_WIDTH);
    return sh[WORD_W-1 -: CHAR_WIDTH];
  endfunction

  function automatic logic is_last(input logic [IDX_W-1:0] i, input logic [LEN_W-1:0] l);
    return (LEN_W'(i) + LEN_W'(1)) == l;
  endfunction

  always_comb begin
    logic [WORD_W-1:0] scan;
    scan  = rom_data;
    len_d = LEN_W'(MAX_CHAR);
    if (trim_q) begin
      len_d = '0;
      for (int i = 0; i < MAX_CHAR; i++) begin
        if (scan[WORD_W-1 -: CHAR_WIDTH] != SPACE_C) begin
          len_d = LEN_W'(i + 1);
        end
        scan = scan << CHAR_WIDTH;
      end
    end
  end

  assign idx_d  = idx_q + IDX_W'(1);
  assign cnt_d  = cnt_q + CNT_W'(1);
  assign accept = valid_q & char_ready;
  assign sel_ok = str_sel < SEL_LIMIT;

  // LOAD spends its first cycle letting the ROM register the selected word,
  // and its second cycle sizing the stream from that word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      trim_q   <= 1'b0;
      reveal_q <= 1'b0;
      phase_q  <= 1'b0;
      idx_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      code_q   <= '0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (sel_ok) begin
              sel_q    <= str_sel;
              trim_q   <= trim_en;
              reveal_q <= reveal_en;
              phase_q  <= 1'b0;
              busy_q   <= 1'b1;
              state_q  <= LOAD;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (!phase_q) begin
            phase_q <= 1'b1;
          end else begin
            len_q  <= len_d;
            idx_q  <= '0;
            cnt_q  <= '0;
            code_q <= code_at(rom_data, '0);
            last_q <= is_last('0, len_d);
            if (len_d == '0) begin
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              valid_q <= 1'b1;
              state_q <= STREAM;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            if (last_q) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              idx_q  <= idx_d;
              code_q <= code_at(rom_data, idx_d);
              last_q <= is_last(idx_d, len_q);
              if (reveal_q) begin
                valid_q <= 1'b0;
                cnt_q   <= '0;
                state_q <= WAIT;
              end
            end
          end
        end
        WAIT: begin
          if (tick) begin
            cnt_q <= cnt_d;
            if (cnt_d == DIV_C) begin
              valid_q <= 1'b1;
              state_q <= STREAM;
            end
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          idx_q   <= '0;
          code_q  <= '0;
          last_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign char_valid = valid_q;
  assign char_code  = code_q;
  assign char_idx   = idx_q;
  assign char_last  = last_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_string_streamer.sv
// Scoreboard bench for string_streamer: expected characters are queued when a
// request is issued and compared as the consumer accepts them.
module tb_string_streamer;

  localparam int CW = 5;
  localparam int MC = 16;
  localparam int SN = 8;
  localparam int SP = 28;
  localparam int RD = 4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] str_sel;
  logic       trim_en;
  logic       reveal_en;
  logic       tick;
  logic       char_ready;
  logic       char_valid;
  logic [4:0] char_code;
  logic [3:0] char_idx;
  logic       char_last;
  logic       busy;
  logic       done;
  logic       err;

  string_streamer #(
    .CHAR_WIDTH (CW),
    .MAX_CHAR   (MC),
    .STRING_NUM (SN),
    .SPACE_CODE (SP),
    .REVEAL_DIV (RD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .str_sel    (str_sel),
    .trim_en    (trim_en),
    .reveal_en  (reveal_en),
    .tick       (tick),
    .char_ready (char_ready),
    .char_valid (char_valid),
    .char_code  (char_code),
    .char_idx   (char_idx),
    .char_last  (char_last),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  typedef struct packed {
    logic [4:0] code;
    logic [3:0] idx;
    logic       last;
  } exp_t;

  exp_t expQ[$];
  exp_t e;

  logic [127:0] romText [SN] = '{
    "HELLO WORLD TEST", "PRESS START     ", "                ", "LEVEL UP!       ",
    "PAUSED          ", "YOU WIN!        ", "READY?          ", "SCORE: HIGH     "
  };

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;
  int startCycle = 0;
  int doneCycle = 0;
  int lastAcceptCycle = 0;
  int doneCount = 0;
  int tickCount = 0;
  bit awaitFirst = 0;
  bit revealMode = 0;
  bit revealWait = 0;
  bit holdActive = 0;
  logic [4:0] heldCode;
  logic [3:0] heldIdx;
  logic       heldLast;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] codeOf(input logic [7:0] ch);
    if (ch >= "A" && ch <= "Z") return 5'(ch - "A");
    case (ch)
      ".":     return 5'd26;
      "!":     return 5'd27;
      "-":     return 5'd29;
      "?":     return 5'd30;
      ":":     return 5'd31;
      default: return 5'd28;
    endcase
  endfunction

  function automatic logic [4:0] expCode(input int sel, input int i);
    logic [127:0] t;
    t = romText[sel] << (8 * i);
    return codeOf(t[127:120]);
  endfunction

  function automatic int expLen(input int sel, input bit trim);
    int len;
    if (!trim) return MC;
    len = 0;
    for (int i = 0; i < MC; i++) begin
      if (expCode(sel, i) != 5'(SP)) len = i + 1;
    end
    return len;
  endfunction

  task automatic applyStimulus(input int sel, input bit trim, input bit reveal);
    int len;
    exp_t item;
    len = (sel < SN) ? expLen(sel, trim) : 0;
    for (int i = 0; i < len; i++) begin
      item.code = expCode(sel, i);
      item.idx  = 4'(i);
      item.last = (i == len - 1);
      expQ.push_back(item);
    end
    @(posedge clk); #1;
    start     = 1'b1;
    str_sel   = 4'(sel);
    trim_en   = trim;
    reveal_en = reveal;
    @(posedge clk); #1;
    startCycle = cycleCnt;
    awaitFirst = (len > 0);
    start      = 1'b0;
  endtask

  task automatic runStream(input int sel, input bit trim, input bit reveal, input int mode);
    int d0;
    revealMode = reveal;
    d0 = doneCount;
    applyStimulus(sel, trim, reveal);
    for (int c = 0; c < 3000 && doneCount == d0; c++) begin
      @(posedge clk); #1;
      char_ready = !(mode == 1 && c >= 6 && c < 13);
      tick       = reveal && (c % 10 == 9);
      start      = (mode == 1 && c == 8);
      str_sel    = (mode == 1) ? 4'd1 : str_sel;
    end
    start      = 1'b0;
    tick       = 1'b0;
    char_ready = 1'b1;
    checkOutput("done_seen", doneCount - d0, 1);
    checkOutput("sb_empty", expQ.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      holdActive = 0;
      revealWait = 0;
      awaitFirst = 0;
    end else begin
      if (holdActive) begin
        checkOutput("hold_valid", char_valid, 1);
        if (char_valid) begin
          checkOutput("hold_code", char_code, heldCode);
          checkOutput("hold_idx", char_idx, heldIdx);
          checkOutput("hold_last", char_last, heldLast);
        end
      end
      if (char_valid && !char_ready) begin
        holdActive = 1;
        heldCode   = char_code;
        heldIdx    = char_idx;
        heldLast   = char_last;
      end else begin
        holdActive = 0;
      end
      if (char_valid && awaitFirst) begin
        awaitFirst = 0;
        checkOutput("latency", cycleCnt - startCycle, 2);
      end
      if (revealWait) begin
        if (char_valid) begin
          checkOutput("reveal_ticks", tickCount, RD);
          revealWait = 0;
        end else if (tick) begin
          tickCount++;
        end
      end
      if (char_valid && char_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_char", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("char_code", char_code, e.code);
          checkOutput("char_idx", char_idx, e.idx);
          checkOutput("char_last", char_last, e.last);
          lastAcceptCycle = cycleCnt;
          if (revealMode && !e.last) begin
            revealWait = 1;
            tickCount  = 0;
          end
        end
      end
      if (done) begin
        doneCount++;
        doneCycle = cycleCnt;
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, char_valid, 0);
    checkOutput({tag, "_code"}, char_code, 0);
    checkOutput({tag, "_idx"}, char_idx, 0);
    checkOutput({tag, "_last"}, char_last, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_err"}, err, 0);
  endtask

  initial begin
    int d0;
    rst_n      = 1'b0;
    start      = 1'b0;
    str_sel    = '0;
    trim_en    = 1'b0;
    reveal_en  = 1'b0;
    tick       = 1'b0;
    char_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst_n = 1'b1;

    $display("[TB] full-length stream");
    runStream(0, 1'b0, 1'b0, 0);
    checkOutput("full_done_gap", doneCycle - lastAcceptCycle, 1);

    $display("[TB] trimmed stream");
    runStream(1, 1'b1, 1'b0, 0);
    checkOutput("trim_done_gap", doneCycle - lastAcceptCycle, 1);

    $display("[TB] reveal pacing");
    runStream(5, 1'b1, 1'b1, 0);
    revealMode = 0;

    $display("[TB] backpressure with ignored start");
    runStream(0, 1'b0, 1'b0, 1);

    $display("[TB] invalid select");
    @(posedge clk); #1;
    start   = 1'b1;
    str_sel = 4'(SN);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("err_pulse", err, 1);
    checkOutput("err_busy", busy, 0);
    @(posedge clk); #1;
    checkOutput("err_clear", err, 0);
    checkOutput("err_busy_after", busy, 0);

    $display("[TB] all-space string");
    runStream(2, 1'b1, 1'b0, 0);
    checkOutput("blank_done_latency", doneCycle - startCycle, 2);

    $display("[TB] reset mid-stream");
    applyStimulus(0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkAllZero("midreset");
    expQ.delete();
    d0 = doneCount;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("no_done_after_reset", doneCount - d0, 0);
    checkOutput("idle_after_reset", busy, 0);
    runStream(3, 1'b1, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
